// File: rtl/rvx_spi_subordinate_pkg.sv
// Shared register map, STATUS bit positions, FSM encoding and the TX load rule
// for the SPI subordinate.
package rvx_spi_subordinate_pkg;

  localparam logic [4:0] RVX_SPI_SUB_MODE_REG_ADDR   = 5'h00;
  localparam logic [4:0] RVX_SPI_SUB_TX_REG_ADDR     = 5'h04;
  localparam logic [4:0] RVX_SPI_SUB_RX_REG_ADDR     = 5'h08;
  localparam logic [4:0] RVX_SPI_SUB_STATUS_REG_ADDR = 5'h0C;

  localparam int RVX_SPI_SUB_STATUS_RX_VALID_BIT = 0;
  localparam int RVX_SPI_SUB_STATUS_TX_FULL_BIT  = 1;
  localparam int RVX_SPI_SUB_STATUS_OVERRUN_BIT  = 2;
  localparam int RVX_SPI_SUB_STATUS_UNDERRUN_BIT = 3;
  localparam int RVX_SPI_SUB_STATUS_ACTIVE_BIT   = 4;

  typedef enum logic {
    SUB_IDLE   = 1'b0,
    SUB_ACTIVE = 1'b1
  } sub_state_e;

  // Byte presented to the manager at the start of each byte slot.
  function automatic logic [7:0] tx_load_byte(input logic tx_full, input logic [7:0] tx_buf);
    return tx_full ? tx_buf : 8'h00;
  endfunction

endpackage

// File: rtl/rvx_sync_edge.sv
// Multi-flop synchronizer with a history flop; reports the synced level and
// single-cycle rise/fall pulses.
module rvx_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    hist_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/rvx_spi_subordinate.sv
// SPI subordinate: oversamples sclk/mosi/cs in the system clock domain, shifts
// bytes in both directions and exposes MODE/TX/RX/STATUS on the RVX IO bus.
module rvx_spi_subordinate
  import rvx_spi_subordinate_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  rw_address,
  output logic [31:0] read_data,
  input  logic        read_request,
  output logic        read_response,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_strobe,
  input  logic        write_request,
  output logic        write_response,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        cs,
  output logic        miso
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  rvx_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clock(clock), .reset(reset), .d(sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  rvx_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clock(clock), .reset(reset), .d(cs),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  rvx_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clock(clock), .reset(reset), .d(mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  sub_state_e  state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  tx_buf_q, tx_buf_d;
  logic        tx_full_q, tx_full_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        overrun_q, overrun_d;
  logic        underrun_q, underrun_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        first_edge_q, first_edge_d;
  logic        miso_q, miso_d;
  logic [31:0] read_data_q, read_data_d;
  logic        read_response_q, read_response_d;
  logic        write_response_q, write_response_d;

  logic        cpha, cpol, cs_low, lead_edge, trail_edge, sample_edge, shift_edge;
  logic        write_ok, load;
  logic [31:0] status_vec;

  assign cpha       = mode_q[0];
  assign cpol       = mode_q[1];
  assign cs_low     = ~cs_lvl;
  assign lead_edge  = cs_low & (cpol ? sclk_fall : sclk_rise);
  assign trail_edge = cs_low & (cpol ? sclk_rise : sclk_fall);
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge  : trail_edge;
  assign write_ok    = write_request & (&write_strobe);

  always_comb begin
    state_d          = state_q;
    mode_d           = mode_q;
    tx_buf_d         = tx_buf_q;
    tx_full_d        = tx_full_q;
    rx_data_d        = rx_data_q;
    rx_valid_d       = rx_valid_q;
    overrun_d        = overrun_q;
    underrun_d       = underrun_q;
    rx_shift_d       = rx_shift_q;
    tx_shift_d       = tx_shift_q;
    bit_cnt_d        = bit_cnt_q;
    first_edge_d     = first_edge_q;
    load             = 1'b0;
    read_response_d  = read_request;
    write_response_d = write_request;
    read_data_d      = 32'h0;

    status_vec = 32'h0;
    status_vec[RVX_SPI_SUB_STATUS_RX_VALID_BIT] = rx_valid_q;
    status_vec[RVX_SPI_SUB_STATUS_TX_FULL_BIT]  = tx_full_q;
    status_vec[RVX_SPI_SUB_STATUS_OVERRUN_BIT]  = overrun_q;
    status_vec[RVX_SPI_SUB_STATUS_UNDERRUN_BIT] = underrun_q;
    status_vec[RVX_SPI_SUB_STATUS_ACTIVE_BIT]   = cs_low;

    if (read_request) begin
      case (rw_address)
        RVX_SPI_SUB_MODE_REG_ADDR:   read_data_d = {30'h0, mode_q};
        RVX_SPI_SUB_TX_REG_ADDR:     read_data_d = {24'h0, tx_buf_q};
        RVX_SPI_SUB_RX_REG_ADDR: begin
          read_data_d = {24'h0, rx_data_q};
          rx_valid_d  = 1'b0;
        end
        RVX_SPI_SUB_STATUS_REG_ADDR: read_data_d = status_vec;
        default:                     read_data_d = 32'h0;
      endcase
    end

    // Bus-side clears come first so that SPI-side sets below take priority.
    if (write_ok) begin
      case (rw_address)
        RVX_SPI_SUB_MODE_REG_ADDR: mode_d = write_data[1:0];
        RVX_SPI_SUB_TX_REG_ADDR: begin
          if (!tx_full_q) begin
            tx_buf_d  = write_data[7:0];
            tx_full_d = 1'b1;
          end
        end
        RVX_SPI_SUB_STATUS_REG_ADDR: begin
          if (write_data[RVX_SPI_SUB_STATUS_OVERRUN_BIT])  overrun_d  = 1'b0;
          if (write_data[RVX_SPI_SUB_STATUS_UNDERRUN_BIT]) underrun_d = 1'b0;
        end
        default: ;
      endcase
    end

    case (state_q)
      SUB_IDLE: begin
        bit_cnt_d = 4'd0;
        if (cs_fall) begin
          state_d      = SUB_ACTIVE;
          first_edge_d = 1'b1;
          load         = 1'b1;
        end
      end
      SUB_ACTIVE: begin
        if (cs_rise) begin
          state_d   = SUB_IDLE;
          bit_cnt_d = 4'd0;
        end else begin
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[6:0], mosi_lvl};
            if (bit_cnt_q == 4'd7) begin
              rx_data_d    = {rx_shift_q[6:0], mosi_lvl};
              rx_valid_d   = 1'b1;
              overrun_d    = overrun_q | rx_valid_q;
              bit_cnt_d    = 4'd0;
              first_edge_d = 1'b1;
              load         = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
          // A freshly loaded byte must keep its MSB on miso through the first
          // shift edge of its slot; with cpha=0 that only arises on a reload.
          if (shift_edge) begin
            first_edge_d = 1'b0;
            if (!(first_edge_q && (cpha || bit_cnt_q == 4'd0))) begin
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
          end
        end
      end
      default: state_d = SUB_IDLE;
    endcase

    if (load) begin
      tx_shift_d = tx_load_byte(tx_full_q, tx_buf_q);
      if (tx_full_q) tx_full_d  = 1'b0;
      else           underrun_d = 1'b1;
    end

    miso_d = (state_d == SUB_ACTIVE) ? tx_shift_d[7] : 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= SUB_IDLE;
      mode_q           <= 2'b00;
      tx_buf_q         <= 8'h00;
      tx_full_q        <= 1'b0;
      rx_data_q        <= 8'h00;
      rx_valid_q       <= 1'b0;
      overrun_q        <= 1'b0;
      underrun_q       <= 1'b0;
      rx_shift_q       <= 8'h00;
      tx_shift_q       <= 8'h00;
      bit_cnt_q        <= 4'd0;
      first_edge_q     <= 1'b0;
      miso_q           <= 1'b0;
      read_data_q      <= 32'h0;
      read_response_q  <= 1'b0;
      write_response_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      mode_q           <= mode_d;
      tx_buf_q         <= tx_buf_d;
      tx_full_q        <= tx_full_d;
      rx_data_q        <= rx_data_d;
      rx_valid_q       <= rx_valid_d;
      overrun_q        <= overrun_d;
      underrun_q       <= underrun_d;
      rx_shift_q       <= rx_shift_d;
      tx_shift_q       <= tx_shift_d;
      bit_cnt_q        <= bit_cnt_d;
      first_edge_q     <= first_edge_d;
      miso_q           <= miso_d;
      read_data_q      <= read_data_d;
      read_response_q  <= read_response_d;
      write_response_q <= write_response_d;
    end
  end

  assign read_data      = read_data_q;
  assign read_response  = read_response_q;
  assign write_response = write_response_q;
  assign miso           = miso_q;

  logic unused_bits;
  assign unused_bits = ^{mosi_rise, mosi_fall, write_data[31:8], rx_shift_q[7]};

endmodule

// File: tb/tb_rvx_spi_subordinate.sv
// Bench for rvx_spi_subordinate: drives an SPI manager at bit level and checks
// bus reads and manager-received bytes against a transaction-level model.
module tb_rvx_spi_subordinate;

  localparam int HALF = 8;
  localparam logic [4:0] A_MODE = 5'h00;
  localparam logic [4:0] A_TX   = 5'h04;
  localparam logic [4:0] A_RX   = 5'h08;
  localparam logic [4:0] A_STAT = 5'h0C;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  rw_address;
  logic [31:0] read_data;
  logic        read_request;
  logic        read_response;
  logic [31:0] write_data;
  logic [3:0]  write_strobe;
  logic        write_request;
  logic        write_response;
  logic        sclk, mosi, cs, miso;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model state
  logic       m_cpol, m_cpha;
  logic       m_rx_valid, m_tx_full, m_overrun, m_underrun;
  logic [7:0] m_rx_data, m_tx_buf, m_cur;

  rvx_spi_subordinate #(.SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .rw_address(rw_address),
    .read_data(read_data), .read_request(read_request), .read_response(read_response),
    .write_data(write_data), .write_strobe(write_strobe), .write_request(write_request),
    .write_response(write_response), .sclk(sclk), .mosi(mosi), .cs(cs), .miso(miso)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status(input logic act);
    return {27'h0, act, m_underrun, m_overrun, m_tx_full, m_rx_valid};
  endfunction

  task automatic m_reset();
    m_cpol = 0; m_cpha = 0; m_rx_valid = 0; m_tx_full = 0; m_overrun = 0;
    m_underrun = 0; m_rx_data = 0; m_tx_buf = 0; m_cur = 0;
  endtask

  task automatic m_tx_write(input logic [7:0] b);
    if (!m_tx_full) begin m_tx_buf = b; m_tx_full = 1; end
  endtask

  task automatic m_load();
    if (m_tx_full) begin m_cur = m_tx_buf; m_tx_full = 0; end
    else begin m_cur = 8'h00; m_underrun = 1; end
  endtask

  task automatic m_byte_done(input logic [7:0] b);
    if (m_rx_valid) m_overrun = 1;
    m_rx_valid = 1;
    m_rx_data  = b;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    rw_address = a; write_data = d; write_strobe = s; write_request = 1;
    tick(1);
    write_request = 0;
    check("write_response", 32'(write_response), 32'd1);
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    rw_address = a; read_request = 1;
    tick(1);
    read_request = 0;
    check("read_response", 32'(read_response), 32'd1);
    d = read_data;
  endtask

  task automatic read_rx(input string tag);
    logic [31:0] d;
    bus_read(A_RX, d);
    check(tag, d, 32'(m_rx_data));
    m_rx_valid = 0;
  endtask

  task automatic read_status(input string tag);
    logic [31:0] d;
    bus_read(A_STAT, d);
    check(tag, d, m_status(1'b0));
  endtask

  task automatic clear_flags();
    bus_write(A_STAT, 32'h0000_000C, 4'hF);
    m_overrun = 0; m_underrun = 0;
  endtask

  task automatic set_mode(input logic cpol, input logic cpha);
    logic [31:0] d;
    m_cpol = cpol; m_cpha = cpha;
    sclk = cpol;
    bus_write(A_MODE, {30'h0, cpol, cpha}, 4'hF);
    bus_read(A_MODE, d);
    check("mode_readback", d, {30'h0, cpol, cpha});
    tick(HALF);
  endtask

  task automatic cs_begin();
    sclk = m_cpol;
    tick(HALF);
    cs = 0;
    m_load();
    tick(HALF);
  endtask

  task automatic cs_end();
    tick(HALF);
    sclk = m_cpol;
    cs = 1;
    tick(2 * HALF);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (!m_cpha) begin
        mosi = tx[i];
        tick(HALF);
        rx[i] = miso;
        sclk = ~m_cpol;
        tick(HALF);
        sclk = m_cpol;
      end else begin
        sclk = ~m_cpol;
        mosi = tx[i];
        tick(HALF);
        rx[i] = miso;
        sclk = m_cpol;
        tick(HALF);
      end
    end
  endtask

  task automatic spi_byte(input string tag, input logic [7:0] tx);
    logic [7:0] rx;
    spi_bits(tx, 8, rx);
    check({tag, "_miso"}, 32'(rx), 32'(m_cur));
    m_byte_done(tx);
    m_load();
  endtask

  task automatic exchange(input string tag, input logic cpol, input logic cpha,
                          input logic [7:0] txb, input logic [7:0] mob);
    set_mode(cpol, cpha);
    bus_write(A_TX, 32'(txb), 4'hF);
    m_tx_write(txb);
    cs_begin();
    spi_byte(tag, mob);
    cs_end();
    read_status({tag, "_status"});
    read_rx({tag, "_rx"});
    read_status({tag, "_status_after_rx"});
    clear_flags();
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  rxb;
    m_reset();
    reset = 1; rw_address = 0; read_request = 0; write_request = 0;
    write_data = 0; write_strobe = 0; sclk = 0; mosi = 0; cs = 1;
    tick(4);
    check("reset_read_data", read_data, 32'h0);
    check("reset_read_response", 32'(read_response), 32'h0);
    check("reset_write_response", 32'(write_response), 32'h0);
    check("reset_miso", 32'(miso), 32'h0);
    reset = 0;
    tick(1);
    read_status("reset_status");
    bus_read(A_MODE, d);
    check("reset_mode", d, 32'h0);
    bus_read(5'h14, d);
    check("unmapped_read", d, 32'h0);

    // All four modes
    exchange("mode0", 1'b0, 1'b0, 8'hA5, 8'h3C);
    exchange("mode1", 1'b0, 1'b1, 8'h96, 8'h69);
    exchange("mode2", 1'b1, 1'b0, 8'h96, 8'h69);
    exchange("mode3", 1'b1, 1'b1, 8'h96, 8'h69);

    // Two-byte burst without reading RX in between
    set_mode(1'b0, 1'b0);
    bus_write(A_TX, 32'h5A, 4'hF); m_tx_write(8'h5A);
    cs_begin();
    spi_byte("burst0", 8'h11);
    bus_write(A_TX, 32'hC7, 4'hF); m_tx_write(8'hC7);
    spi_byte("burst1", 8'h22);
    cs_end();
    read_status("burst_status");
    read_rx("burst_rx");
    bus_write(A_STAT, 32'h4, 4'hF); m_overrun = 0;
    read_status("burst_overrun_cleared");
    clear_flags();

    // Underrun, then a dropped second TX write
    cs_begin();
    spi_byte("underrun", 8'h44);
    cs_end();
    read_status("underrun_status");
    read_rx("underrun_rx");
    clear_flags();
    bus_write(A_TX, 32'h77, 4'hF); m_tx_write(8'h77);
    bus_write(A_TX, 32'h88, 4'hF); m_tx_write(8'h88);
    bus_read(A_TX, d);
    check("tx_drop_readback", d, 32'(m_tx_buf));
    cs_begin();
    spi_byte("tx_drop", 8'h19);
    cs_end();
    read_status("tx_drop_status");
    clear_flags();

    // Partial strobes do not write
    bus_write(A_TX, 32'hEE, 4'h7);
    read_status("partial_strobe_status");

    // Abort after 5 bits with rx_valid still set from the last byte
    cs_begin();
    spi_bits(8'hB3, 5, rxb);
    cs_end();
    read_status("abort_status");
    read_rx("abort_rx_old");
    clear_flags();
    exchange("after_abort", 1'b0, 1'b0, 8'h0F, 8'hF0);

    // Reset in the middle of a byte
    bus_write(A_TX, 32'hC3, 4'hF); m_tx_write(8'hC3);
    cs_begin();
    spi_bits(8'hAA, 4, rxb);
    reset = 1;
    tick(2);
    reset = 0;
    rw_address = A_STAT; read_request = 1;
    tick(1);
    read_request = 0;
    check("midreset_status", read_data, 32'h0);
    check("midreset_miso", 32'(miso), 32'h0);
    sclk = 0; cs = 1;
    tick(4 * HALF);
    m_reset();
    clear_flags();
    read_status("midreset_clean");
    exchange("after_reset", 1'b0, 1'b0, 8'h5E, 8'hE7);

    // Randomised exchanges
    for (int k = 0; k < 6; k++) begin
      logic [1:0] md;
      md = 2'($urandom_range(0, 3));
      exchange("rand", md[1], md[0], 8'($urandom), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
